// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner with a double-buffered frame, per-slot blanking and a frame pulse.
// Optional leading-zero blanking is compiled in when SEVEN_SEGMENT_LZB_EN is defined.
module seven_segment_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            display,
  output logic                  decimal,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame
);

  localparam int unsigned DATA_W  = 4 * DIGITS;
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);

  logic [PRESC_W-1:0] r_presc;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_act_data;
  logic [DIGITS-1:0]  r_act_dp;
  logic [DATA_W-1:0]  r_pend_data;
  logic [DIGITS-1:0]  r_pend_dp;
  logic               r_pend_valid;
  logic [6:0]         r_display;
  logic               r_decimal;
  logic [DIGITS-1:0]  r_digit_sel;
  logic               r_frame;

  logic               w_tick;
  logic               w_boundary;
  logic [3:0]         w_nib;
  logic               w_dp;
  logic [DIGITS-1:0]  w_sel;
  logic               w_lz_blank;
  logic [6:0]         w_seg;

  function automatic logic [6:0] f_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  assign w_tick     = enable && (r_presc == PRESC_W'(REFRESH_DIV - 1));
  assign w_boundary = w_tick && (r_idx == IDX_W'(DIGITS - 1));

  // Select the active digit's nibble, dp bit and one-hot enable.
  always_comb begin
    w_nib      = '0;
    w_dp       = 1'b0;
    w_sel      = '0;
    w_lz_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_act_data[4*k +: 4];
        w_dp     = r_act_dp[k];
        w_sel[k] = 1'b1;
`ifdef SEVEN_SEGMENT_LZB_EN
        // Digit k>0 is a leading zero when it and every higher nibble are zero.
        if (k > 0) w_lz_blank = ((r_act_data >> (4 * k)) == '0);
`endif
      end
    end
  end

  assign w_seg = w_lz_blank ? 7'h00 : f_encode(w_nib);

  // Prescaler, digit index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_display   <= '0;
      r_decimal   <= 1'b0;
      r_digit_sel <= '0;
      r_frame     <= 1'b0;
    end else begin
      if (enable) begin
        r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
      end
      if (w_tick) begin
        r_idx <= w_boundary ? '0 : r_idx + IDX_W'(1);
      end
      r_frame <= w_boundary;
      if (!enable || w_tick) begin
        r_display   <= '0;
        r_decimal   <= 1'b0;
        r_digit_sel <= '0;
      end else begin
        r_display   <= w_seg;
        r_decimal   <= w_dp;
        r_digit_sel <= w_sel;
      end
    end
  end

  // Double buffer: active only changes on a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else if (load && w_boundary) begin
      r_act_data   <= data;
      r_act_dp     <= dp;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_act_data   <= r_pend_data;
        r_act_dp     <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pend_data  <= data;
        r_pend_dp    <= dp;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign display   = r_display;
  assign decimal   = r_decimal;
  assign digit_sel = r_digit_sel;
  assign frame     = r_frame;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Randomized, self-checking bench for seven_segment_scan (DIGITS=4, REFRESH_DIV=4) against a behavioural model.
module tb_seven_segment_scan;

  localparam int DG = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [6:0]  display;
  logic        decimal;
  logic [3:0]  digit_sel;
  logic        frame;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Behavioural model state and the outputs it predicts after the next edge.
  int          m_presc = 0;
  int          m_idx   = 0;
  logic [15:0] m_act   = '0;
  logic [3:0]  m_actdp = '0;
  logic [15:0] m_pend  = '0;
  logic [3:0]  m_penddp = '0;
  bit          m_pv    = 1'b0;
  logic [6:0]  e_disp  = '0;
  logic        e_dec   = 1'b0;
  logic [3:0]  e_sel   = '0;
  logic        e_frame = 1'b0;

  seven_segment_scan #(.DIGITS(DG), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data(data), .dp(dp), .load(load),
    .display(display), .decimal(decimal), .digit_sel(digit_sel), .frame(frame)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic step(input bit r, input bit en, input bit ld, input logic [15:0] d, input logic [3:0] p);
    bit tick;
    bit bnd;
    int nib;
    rst = r; enable = en; load = ld; data = d; dp = p;
    if (r) begin
      m_presc = 0; m_idx = 0; m_act = '0; m_actdp = '0; m_pend = '0; m_penddp = '0; m_pv = 0;
      e_disp = '0; e_dec = 0; e_sel = '0; e_frame = 0;
    end else begin
      tick = en && (m_presc == RD - 1);
      bnd  = tick && (m_idx == DG - 1);
      e_frame = bnd;
      if (!en || tick) begin
        e_disp = '0; e_dec = 0; e_sel = '0;
      end else begin
        nib    = int'((m_act >> (4 * m_idx)) & 16'hF);
        e_sel  = 4'(1 << m_idx);
        e_dec  = m_actdp[m_idx];
        e_disp = seg_tab[nib];
`ifdef SEVEN_SEGMENT_LZB_EN
        if (m_idx > 0 && (m_act >> (4 * m_idx)) == 16'h0) e_disp = '0;
`endif
      end
      if (ld && bnd) begin
        m_act = d; m_actdp = p; m_pv = 0;
      end else begin
        if (bnd && m_pv) begin m_act = m_pend; m_actdp = m_penddp; m_pv = 0; end
        if (ld) begin m_pend = d; m_penddp = p; m_pv = 1; end
      end
      if (en) begin
        m_presc = tick ? 0 : m_presc + 1;
        if (tick) m_idx = (m_idx + 1) % DG;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 16'hFFFF, 4'hF);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== 13'h0) begin
        n_fail++;
        $display("FAIL reset: got %h/%b/%b/%b want all zero", display, decimal, digit_sel, frame);
      end
    end
  endtask

  task automatic test_basic();
    bit seen = 0;
    logic [6:0] exp_seg [4] = '{7'h47, 7'h77, 7'h6D, 7'h30};
    logic [6:0] xd;
    logic [3:0] xs;
    step(0, 1, 1, 16'h12AF, 4'b0010);
    for (int c = 0; c < 40 && !seen; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {e_disp, e_dec, e_sel, e_frame}) begin
        n_fail++;
        $display("FAIL basic_model: got %h/%b/%b/%b want %h/%b/%b/%b",
                 display, decimal, digit_sel, frame, e_disp, e_dec, e_sel, e_frame);
      end
      seen = (frame === 1'b1);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL basic_frame: got no frame want frame within 40 cycles"); end
    for (int j = 0; j < 16; j++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      xd = (j % 4 < 3) ? exp_seg[j / 4] : 7'h00;
      xs = (j % 4 < 3) ? 4'(1 << (j / 4)) : 4'h0;
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {xd, (j % 4 < 3) && (j / 4 == 1), xs, (j == 15)}) begin
        n_fail++;
        $display("FAIL basic_slot%0d: got %h/%b/%b/%b want %h/%b/%b/%b", j, display, decimal, digit_sel, frame,
                 xd, (j % 4 < 3) && (j / 4 == 1), xs, (j == 15));
      end
    end
  endtask

  task automatic test_midframe_load();
    bit hit = 0;
    step(0, 1, 1, 16'h1234, 4'h0);
    for (int c = 0; c < 40 && !(m_idx == 1 && m_act == 16'h1234); c++) step(0, 1, 0, 16'h0, 4'h0);
    step(0, 1, 1, 16'h0008, 4'h0);
    for (int c = 0; c < 40; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {e_disp, e_dec, e_sel, e_frame}) begin
        n_fail++;
        $display("FAIL midload_model: got %h/%b/%b/%b want %h/%b/%b/%b",
                 display, decimal, digit_sel, frame, e_disp, e_dec, e_sel, e_frame);
      end
      if (!hit && digit_sel === 4'b0100) begin
        hit = 1;
        n_checks++;
        if (display !== 7'h6D) begin n_fail++; $display("FAIL midload_d2: got %h want 6d", display); end
      end
    end
  endtask

  task automatic test_enable();
    for (int c = 0; c < 20 && m_presc != 1; c++) step(0, 1, 0, 16'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 16'h0, 4'h0);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== 13'h0) begin
        n_fail++;
        $display("FAIL enable_off: got %h/%b/%b/%b want all zero", display, decimal, digit_sel, frame);
      end
    end
    for (int c = 0; c < 20; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {e_disp, e_dec, e_sel, e_frame}) begin
        n_fail++;
        $display("FAIL enable_resume: got %h/%b/%b/%b want %h/%b/%b/%b",
                 display, decimal, digit_sel, frame, e_disp, e_dec, e_sel, e_frame);
      end
    end
  endtask

  task automatic test_boundary_load();
    int guard = 0;
    while (!(m_presc == RD - 1 && m_idx == DG - 1) && guard < 40) begin
      step(0, 1, 0, 16'h0, 4'h0);
      guard++;
    end
    step(0, 1, 1, 16'hFFFF, 4'h0);
    n_checks++;
    if (frame !== 1'b1) begin n_fail++; $display("FAIL bndload_frame: got %b want 1", frame); end
    step(0, 1, 0, 16'h0, 4'h0);
    n_checks++;
    if ({display, digit_sel} !== {7'h47, 4'b0001}) begin
      n_fail++;
      $display("FAIL bndload_d0: got %h/%b want 47/0001", display, digit_sel);
    end
    for (int c = 0; c < 24; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {e_disp, e_dec, e_sel, e_frame}) begin
        n_fail++;
        $display("FAIL bndload_model: got %h/%b/%b/%b want %h/%b/%b/%b",
                 display, decimal, digit_sel, frame, e_disp, e_dec, e_sel, e_frame);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    for (int c = 0; c < 20 && !(m_idx == 2 && m_presc == 1); c++) step(0, 1, 0, 16'h0, 4'h0);
    step(1, 1, 0, 16'h0, 4'h0);
    n_checks++;
    if ({display, decimal, digit_sel, frame} !== 13'h0) begin
      n_fail++;
      $display("FAIL rstmid_zero: got %h/%b/%b/%b want all zero", display, decimal, digit_sel, frame);
    end
    for (int c = 1; c <= 30; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      if (first < 0 && frame === 1'b1) first = c;
    end
    n_checks++;
    if (first != 16) begin n_fail++; $display("FAIL rstmid_frame: got cycle %0d want 16", first); end
  endtask

  task automatic test_lzb();
    bit seen = 0;
    logic [6:0] hi_exp;
`ifdef SEVEN_SEGMENT_LZB_EN
    hi_exp = 7'h00;
`else
    hi_exp = 7'h7E;
`endif
    step(0, 1, 1, 16'h0050, 4'h0);
    for (int c = 0; c < 40 && !seen; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      seen = (frame === 1'b1);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL lzb_frame: got no frame want frame within 40 cycles"); end
    for (int j = 0; j < 16; j++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      if (j % 4 == 0) begin
        n_checks++;
        if (display !== ((j == 0) ? 7'h7E : (j == 4) ? 7'h5B : hi_exp)) begin
          n_fail++;
          $display("FAIL lzb_slot%0d: got %h want %h", j / 4, display,
                   (j == 0) ? 7'h7E : (j == 4) ? 7'h5B : hi_exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) step(0, 1, 1, 16'($urandom), 4'($urandom));
    for (int c = 0; c < 36; c++) begin
      step(0, 1, 0, 16'h0, 4'h0);
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {e_disp, e_dec, e_sel, e_frame}) begin
        n_fail++;
        $display("FAIL b2b_model: got %h/%b/%b/%b want %h/%b/%b/%b",
                 display, decimal, digit_sel, frame, e_disp, e_dec, e_sel, e_frame);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 150) == 0, ($urandom % 10) != 0, ($urandom % 6) == 0,
           (($urandom % 3) == 0) ? 16'(($urandom % 16) << 4) : 16'($urandom), 4'($urandom));
      n_checks++;
      if ({display, decimal, digit_sel, frame} !== {e_disp, e_dec, e_sel, e_frame}) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 display, decimal, digit_sel, frame, e_disp, e_dec, e_sel, e_frame);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_midframe_load();
    test_enable();
    test_boundary_load();
    test_reset_mid();
    test_lzb();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 1000, clk cycles per digit slot; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  scan enable; low freezes the scan and blanks the outputs.
REQ-006 data  input  4*DIGITS  hex nibbles; digit k = data[4k+3:4k], digit 0 least significant.
REQ-007 dp  input  DIGITS  decimal-point request per digit.
REQ-008 load  input  1  one-cycle strobe capturing data and dp.
REQ-009 display  output  7  registered segments {6..0}, active-high; 6=top, 5=upper right, 4=lower right, 3=bottom, 2=lower left, 1=upper left, 0=middle.
REQ-010 decimal  output  1  registered decimal-point segment, active-high.
REQ-011 digit_sel  output  DIGITS  registered one-hot digit enable, active-high.
REQ-012 frame  output  1  registered one-cycle pulse at each frame boundary.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 while enable=1, hold while enable=0, and assert internal tick on terminal count, then wrap to 0.
REQ-014 On tick the digit index SHALL advance idx+1, wrapping DIGITS-1 -> 0 (frame boundary).
REQ-015 frame SHALL be 1 for exactly the cycle after each frame-boundary tick edge, else 0.
REQ-016 Segment encoding (display hex): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47.
REQ-017 Each cycle outputs SHALL register: digit_sel=onehot(idx), display=encode(active nibble idx), decimal=active dp[idx]; latency one cycle from idx/active change.
REQ-018 Anti-ghosting: in the cycle where tick=1, outputs SHALL register all-zero, giving one blank cycle per slot.
REQ-019 enable=0: display, decimal, digit_sel SHALL register 0; idx and prescaler hold; frame=0.
REQ-020 Double buffering: load SHALL write data/dp into a pending register and set pending_valid.
REQ-021 At a frame-boundary tick, if pending_valid, active SHALL take pending and pending_valid clear; active never changes mid-frame.
REQ-022 load coincident with a frame-boundary tick SHALL write data/dp straight into active, leaving pending_valid 0.
REQ-023 Multiple loads within one frame: the last one wins.
REQ-024 DIGITS=1: every tick is a frame boundary; digit_sel[0] still blanks per REQ-018.

Reset
REQ-025 rst=1 SHALL, at the next edge, clear prescaler, idx, active, pending, pending_valid and drive display=0, decimal=0, digit_sel=0, frame=0.
REQ-026 rst SHALL override enable, load and tick in the same cycle; reset mid-scan restarts at digit 0 with prescaler 0.

Configuration
REQ-027 Macro SEVEN_SEGMENT_LZB_EN defined: leading-zero blanking -- digit k>0 whose nibble and all higher nibbles of active are 0 SHALL show display=0, decimal=dp[k], digit_sel unchanged.
REQ-028 Digit 0 SHALL never be blanked by LZB; all-zero data shows a single 0 (7E).
REQ-029 Macro undefined: no blanking logic is present; every digit shows its encoded nibble.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-030 rst, enable=1, load data=16'h12AF dp=4'b0010 at first boundary -> next frame slots: d0 47, d1 77 decimal=1, d2 6D, d3 30; each slot 3 lit cycles + 1 blank.
REQ-031 load 16'h0008 mid-frame while showing 16'h1234 -> remaining slots still show 1234; after frame pulse all slots show 0008 encoding.
REQ-032 enable=0 for 10 cycles mid-slot -> outputs 0, frame=0; on re-enable scan resumes same idx and prescaler value.
REQ-033 load coincident with boundary tick, data=16'hFFFF -> first slot of new frame shows 47 on digit 0, pending_valid=0.
REQ-034 rst pulsed during digit 2 -> next cycle all outputs 0; scan restarts at digit 0, first frame pulse after 16 cycles.
REQ-035 With SEVEN_SEGMENT_LZB_EN, data=16'h0050 -> d3, d2 display=0, d1 5B, d0 7E; without macro d3, d2 show 7E.
